// File: rtl/softex_fp_vect_bcast_pkg.sv
// Shared types and helpers for the scalar-to-vector broadcaster.
// Holds the floating-point format enumeration and its bit layout, the
// default lane/accumulator formats, the rounding-mode encoding used by the
// narrowing stage, the broadcaster state enum and a ceiling-divide helper.
package softex_fp_vect_bcast_pkg;

  typedef enum logic [0:0] {
    FP32,
    BF16
  } fp_format_e;

  typedef struct packed {
    int unsigned exp_bits;
    int unsigned man_bits;
  } fp_encoding_t;

  localparam fp_format_e FPFORMAT_IN  = BF16;
  localparam fp_format_e FPFORMAT_ACC = FP32;

  // Same encoding as the FPU rounding-mode field.
  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic {
    IDLE,
    STREAM
  } bcast_state_e;

  function automatic fp_encoding_t fmt_to_conf(input fp_format_e fmt);
    fp_encoding_t conf;
    case (fmt)
      BF16:    conf = '{exp_bits: 8, man_bits: 7};
      default: conf = '{exp_bits: 8, man_bits: 23};
    endcase
    return conf;
  endfunction

  function automatic int unsigned fp_width(input fp_format_e fmt);
    fp_encoding_t conf;
    conf = fmt_to_conf(fmt);
    return 1 + conf.exp_bits + conf.man_bits;
  endfunction

  // Number of beats needed to emit len elements over lanes lanes.
  function automatic int unsigned ceil_div(input int unsigned len, input int unsigned lanes);
    return (len + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/softex_fp_vect_bcast_narrow.sv
// Combinational float-to-float narrowing from SRC_FMT to DST_FMT.
// Identical formats pass straight through. Otherwise the destination keeps
// the source exponent width and drops low mantissa bits, rounding per
// mode_i; NaNs become the canonical quiet NaN and overflow lands on Inf or
// max-normal according to the rounding direction. No status flags.
// Ports:
//   mode_i  rounding mode
//   src_i   source value (SRC_FMT)
//   dst_o   narrowed value (DST_FMT)
module softex_fp_vect_bcast_narrow
  import softex_fp_vect_bcast_pkg::*;
#(
  parameter fp_format_e SRC_FMT = FPFORMAT_ACC,
  parameter fp_format_e DST_FMT = FPFORMAT_IN,
  localparam int unsigned SRC_WIDTH = fp_width(SRC_FMT),
  localparam int unsigned DST_WIDTH = fp_width(DST_FMT)
) (
  input  roundmode_e           mode_i,
  input  logic [SRC_WIDTH-1:0] src_i,
  output logic [DST_WIDTH-1:0] dst_o
);

  localparam fp_encoding_t SRC_CONF = fmt_to_conf(SRC_FMT);
  localparam fp_encoding_t DST_CONF = fmt_to_conf(DST_FMT);

  if (SRC_FMT == DST_FMT) begin : g_bypass
    logic unused_mode;
    assign unused_mode = ^mode_i;
    assign dst_o       = src_i;
  end else if ((SRC_CONF.exp_bits != DST_CONF.exp_bits) ||
               (DST_CONF.man_bits >= SRC_CONF.man_bits)) begin : g_unsupported
    $error("narrowing supports only mantissa reduction at equal exponent width");
  end else begin : g_narrow
    localparam int unsigned EXP  = SRC_CONF.exp_bits;
    localparam int unsigned DROP = SRC_CONF.man_bits - DST_CONF.man_bits;
    localparam logic [SRC_WIDTH-1:0] STICKY_MASK =
      (SRC_WIDTH'(1) << (DROP - 1)) - SRC_WIDTH'(1);
    localparam logic [DST_WIDTH-1:0] CANON_NAN =
      {1'b0, {EXP{1'b1}}, 1'b1, {(DST_CONF.man_bits - 1){1'b0}}};

    logic                 sign, guard, sticky, is_nan, round_up;
    logic [DST_WIDTH-1:0] kept;

    assign sign   = src_i[SRC_WIDTH-1];
    assign kept   = src_i[SRC_WIDTH-1 -: DST_WIDTH];
    assign guard  = src_i[DROP-1];
    assign sticky = |(src_i & STICKY_MASK);
    assign is_nan = (&src_i[SRC_WIDTH-2 -: EXP]) & (|src_i[SRC_CONF.man_bits-1:0]);

    always_comb begin
      case (mode_i)
        RNE:     round_up = guard & (sticky | kept[0]);
        RDN:     round_up = sign & (guard | sticky);
        RUP:     round_up = ~sign & (guard | sticky);
        RMM:     round_up = guard;
        default: round_up = 1'b0;
      endcase
    end

    // A carry out of the mantissa increments the exponent; from max-normal
    // it lands exactly on the Inf encoding.
    assign dst_o = is_nan ? CANON_NAN : kept + DST_WIDTH'(round_up);
  end

endmodule

// File: rtl/softex_fp_vect_bcast.sv
// Scalar-to-vector broadcaster. Accepts one accumulator-format scalar plus
// an element count, narrows the scalar once to the lane format and streams
// it replicated over VECT_WIDTH lanes for ceil(len/VECT_WIDTH) beats, with a
// lane strobe on the final partial beat.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   clear_i           synchronous abort/flush (highest priority)
//   enable_i          global stall, blocks both handshakes when low
//   mode_i            rounding mode for the narrowing
//   valid_i/ready_o   command handshake: scalar_i, len_i, tag_i
//   vect_o, strb_o    replicated narrowed scalar and lane-valid mask
//   last_o, tag_o     final beat of the command, command tag
//   valid_o/ready_i   beat handshake
//   busy_o            command in flight
module softex_fp_vect_bcast
  import softex_fp_vect_bcast_pkg::*;
#(
  parameter fp_format_e  IN_FPFORMAT  = FPFORMAT_IN,
  parameter fp_format_e  ACC_FPFORMAT = FPFORMAT_ACC,
  parameter int unsigned VECT_WIDTH   = 1,
  parameter int unsigned LEN_WIDTH    = 16,
  parameter type         TAG_TYPE     = logic,
  localparam int unsigned IN_WIDTH    = fp_width(IN_FPFORMAT),
  localparam int unsigned ACC_WIDTH   = fp_width(ACC_FPFORMAT)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clear_i,
  input  logic                                 enable_i,
  input  roundmode_e                           mode_i,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  input  logic [ACC_WIDTH-1:0]                 scalar_i,
  input  logic [LEN_WIDTH-1:0]                 len_i,
  input  TAG_TYPE                              tag_i,
  output logic [VECT_WIDTH-1:0][IN_WIDTH-1:0]  vect_o,
  output logic [VECT_WIDTH-1:0]                strb_o,
  output logic                                 last_o,
  output TAG_TYPE                              tag_o,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic                                 busy_o
);

  localparam logic [LEN_WIDTH-1:0] VW_LEN = LEN_WIDTH'(VECT_WIDTH);

  bcast_state_e                        state_q, state_d;
  logic [LEN_WIDTH-1:0]                rem_q, rem_d;
  logic [VECT_WIDTH-1:0][IN_WIDTH-1:0] vect_q, vect_d;
  TAG_TYPE                             tag_q, tag_d;
  logic [IN_WIDTH-1:0]                 narrowed;
  logic                                last_beat, accept, xfer;

  softex_fp_vect_bcast_narrow #(
    .SRC_FMT (ACC_FPFORMAT),
    .DST_FMT (IN_FPFORMAT)
  ) i_narrow (
    .mode_i (mode_i),
    .src_i  (scalar_i),
    .dst_o  (narrowed)
  );

  // Beat outputs are decoded from the state and remaining count, so they
  // hold by construction whenever the registers hold.
  assign valid_o   = (state_q == STREAM);
  assign busy_o    = valid_o;
  assign last_beat = valid_o & (rem_q <= VW_LEN);
  assign last_o    = last_beat;
  assign vect_o    = vect_q;
  assign tag_o     = tag_q;

  always_comb begin
    strb_o = '0;
    for (int unsigned k = 0; k < VECT_WIDTH; k++) begin
      strb_o[k] = rem_q > LEN_WIDTH'(k);
    end
  end

  // ready_i feeds ready_o combinationally so the next command can be taken
  // in the same cycle the last beat leaves, with no bubble.
  assign ready_o = enable_i & ~clear_i & ((state_q == IDLE) | (last_beat & ready_i));
  assign accept  = valid_i & ready_o;
  assign xfer    = valid_o & ready_i & enable_i;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    rem_d   = rem_q;
    vect_d  = vect_q;
    tag_d   = tag_q;

    if (clear_i) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      if (xfer) begin
        rem_d = (rem_q > VW_LEN) ? rem_q - VW_LEN : '0;
        if (last_beat) state_d = IDLE;
      end
      // Acceptance only happens from IDLE or on a last-beat transfer, so it
      // safely overrides the countdown above. A zero-length command is
      // consumed without producing beats.
      if (accept) begin
        rem_d   = len_i;
        tag_d   = tag_i;
        state_d = (len_i != '0) ? STREAM : IDLE;
        for (int unsigned k = 0; k < VECT_WIDTH; k++) begin
          vect_d[k] = narrowed;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rem_q   <= '0;
      // NOTE: the lane data register is reset too, so vect_o reads zero out
      // of reset rather than X; it is a handful of flops, not a RAM.
      vect_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      vect_q  <= vect_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: doc/softex_fp_vect_bcast.md
Name: softex_fp_vect_bcast

Overview:
- Scalar-to-vector broadcaster: the expansion counterpart of the vector reduction-sum datapath.
- Accepts one accumulator-format scalar, for example a softmax denominator reciprocal, narrows it once to the input format, and streams it replicated across VECT_WIDTH lanes.
- Emits ceil(len/VECT_WIDTH) beats, with lane strobes on the final partial beat.
- Feeds the per-element multiply/normalise stage of the softmax engine.

Parameters:
- IN_FPFORMAT, softex_pkg::FPFORMAT_IN: lane output format.
- ACC_FPFORMAT, softex_pkg::FPFORMAT_ACC: scalar input format.
- VECT_WIDTH, 1: number of output lanes.
- LEN_WIDTH, 16: width of the element-count field.
- TAG_TYPE, logic: sideband tag, carried from command to every beat.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous abort/flush.
- enable_i  in  1  global stall; when 0 no handshake completes on either side.
- mode_i  in  fpnew_pkg::roundmode_e  rounding mode for the ACC->IN narrowing.
- valid_i  in  1  command valid.
- ready_o  out  1  command ready.
- scalar_i  in  ACC_WIDTH  value to broadcast.
- len_i  in  LEN_WIDTH  number of elements to emit.
- tag_i  in  TAG_TYPE  command tag.
- vect_o  out  VECT_WIDTH x IN_WIDTH  replicated narrowed scalar.
- strb_o  out  VECT_WIDTH  lane-valid mask.
- last_o  out  1  final beat of the command.
- tag_o  out  TAG_TYPE  tag of the current command.
- valid_o  out  1  beat valid.
- ready_i  in  1  downstream ready.
- busy_o  out  1  command in flight.

Behaviour:
- Reset values: state IDLE; valid_o, last_o and busy_o = 0; vect_o, strb_o, tag_o and the remaining-count register = 0.
- Command accept: valid_i & ready_o.
  - ready_o = enable_i & (state==IDLE | (state==STREAM & last_o & ready_i)).
  - This is a combinational ready_i->ready_o path; it is permitted and required for zero-bubble back-to-back commands.
- On accept:
  - scalar_i is narrowed combinationally with mode_i.
  - The narrowed value is registered into every lane of vect_o.
  - rem <= len_i and tag_o <= tag_i.
- Latency: command accepted at cycle t gives its first beat valid_o=1 at t+1.
- FSM IDLE -> STREAM: taken on accept with len_i != 0.
  - Accept with len_i == 0 is consumed and dropped: no beats, state stays IDLE (or goes to IDLE if accepted on a last beat).
- In STREAM:
  - valid_o = 1, busy_o = 1.
  - strb_o[k] = (k < rem); all ones when rem >= VECT_WIDTH.
  - last_o = (rem <= VECT_WIDTH).
  - Beat transfer: valid_o & ready_i & enable_i. On transfer, rem <= rem - VECT_WIDTH (saturating at 0, no wrap).
  - On a last-beat transfer: go to IDLE, unless a new non-zero-length command is accepted in the same cycle, in which case stay in STREAM with the new rem/tag/value.
- Stall: while valid_o=1 and no transfer occurs (ready_i=0 or enable_i=0), vect_o, strb_o, last_o and tag_o hold stable.
- clear_i:
  - Next cycle: IDLE, valid_o=0, busy_o=0, rem=0. Data outputs may hold.
  - A command presented in the same cycle as clear_i is not accepted; ready_o is masked by ~clear_i.
  - clear_i has priority over all transfers.
- Narrowing: when IN_FPFORMAT == ACC_FPFORMAT, the scalar passes through unchanged.
  - Otherwise fpnew F2F rounding per mode_i; NaN is canonical, overflow goes to Inf or max-normal per the rounding mode.
  - Status flags are discarded.
- Asynchronous reset mid-stream returns all state and outputs to the reset values immediately.

Decomposition:
- softex_pkg:
  - Reuses FPFORMAT_IN/FPFORMAT_ACC and fmt_to_conf.
  - Adds a bcast_state_e enum {IDLE, STREAM}.
  - Adds a localparam function ceil_div for beat-count checks.
- Sub-module: fpnew_cast_multi instantiated once with NumPipeRegs=0, F2F, in_valid/out_ready tied high, generated only when the formats differ.
- Optional wrapper sub-module softex_fp_narrow holding that instance and the bypass, for reuse by other blocks.
- FSM, counter and strobe generation stay in the top module.

Test Plan:
- Basic stream: VECT_WIDTH=4, FP32->BF16, scalar 0x3F800000, len=10, ready_i=1.
  - Expect 3 beats starting 1 cycle after accept.
  - Every lane 0x3F80.
  - strb 1111, 1111, 0011.
  - last_o only on beat 3; busy_o low the cycle after.
- Rounding: scalar 0x3F808000, len=4.
  - mode RNE -> lanes 0x3F80.
  - mode RUP -> lanes 0x3F81.
  - mode RTZ -> 0x3F80.
- Backpressure/enable: len=8; drop ready_i for 2 cycles after beat 1, then drop enable_i for 1 cycle.
  - Outputs stable throughout.
  - Exactly 2 transfers total, no duplication or loss.
- Back-to-back: cmd A (len=4, tag 0) then cmd B (len=5, tag 1) held valid.
  - B accepted on A's last-beat cycle.
  - Next cycle B beat 1 with tag_o=1 (zero bubble).
  - B strb 1111 then 0001.
- Zero length and clear:
  - len=0 -> ready_o stays 1, valid_o never rises.
  - len=12 with clear_i pulsed after beat 1 -> valid_o=0 and busy_o=0 the next cycle.
  - A fresh len=4 command afterwards streams correctly.
- Async reset mid-stream: assert rst_ni low between clock edges.
  - valid_o, last_o, busy_o and strb_o go to 0 immediately.
  - After release, ready_o = enable_i.
